// File: rtl/cheby_pkg.sv
// Shared constants, state encoding and Q15 scaling for the Chebyshev T-table writer.
package cheby_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int N_TERMS = 8;

    // T0 = 1.0 is not representable in Q15, so the largest positive word stands in for it.
    localparam logic [DATA_W-1:0] T0_ONE = 16'h7FFF;

    // Q15*Q15 gives Q30; shifting by 14 rather than 15 folds in the factor 2 of 2*x*T(k-1).
    localparam int FRAC_SHIFT = 14;

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        SEED0,
        SEED1,
        MUL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/cheby_step.sv
// One recurrence step: (p >>> 14) - tm2 reduced to a Q15 word.
// With CHEBY_SAT_EN defined the result is clamped and flagged; otherwise it wraps.
module cheby_step
    import cheby_pkg::*;
(
    input  logic signed [PROD_W-1:0] i_p,
    input  logic signed [DATA_W-1:0] i_tm2,
    output logic        [DATA_W-1:0] o_res,
    output logic                     o_sat
);

    logic signed [PROD_W-1:0] p_shift;
    logic signed [PROD_W-1:0] d_full;

    // The true difference fits in 19 bits; the wider width just keeps the range test simple.
    assign p_shift = i_p >>> FRAC_SHIFT;
    assign d_full  = p_shift - PROD_W'(i_tm2);

`ifdef CHEBY_SAT_EN
    logic ovf;

    // Overflow whenever the bits above the Q15 sign bit disagree with it.
    assign ovf = (d_full[PROD_W-1:DATA_W-1] != {(PROD_W-DATA_W+1){1'b0}})
              && (d_full[PROD_W-1:DATA_W-1] != {(PROD_W-DATA_W+1){1'b1}});

    always_comb begin
        o_res = d_full[DATA_W-1:0];
        o_sat = 1'b0;
        if (ovf) begin
            o_sat = 1'b1;
            o_res = d_full[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^d_full[PROD_W-1:DATA_W];
    assign o_res     = d_full[DATA_W-1:0];
    assign o_sat     = 1'b0;
`endif

endmodule

// File: rtl/cheby_t_table_writer.sv
// Fills an 8x16 coefficient RAM with T0(x)..T7(x) in Q15 using T(k) = 2x*T(k-1) - T(k-2).
// Define CHEBY_SAT_EN to clamp out-of-range terms and raise the sticky o_sat flag.
module cheby_t_table_writer
    import cheby_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_x,
    input  logic              c_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_wr_address,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_en,
    output logic              o_sat
);

    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(N_TERMS - 1);
    localparam logic [ADDR_W-1:0] K_FIRST = ADDR_W'(2);

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [DATA_W-1:0]  tm1_q, tm1_d;
    logic signed [DATA_W-1:0]  tm2_q, tm2_d;
    logic signed [PROD_W-1:0]  p_q, p_d;
    logic        [ADDR_W-1:0]  k_q, k_d;
    logic                      sat_q, sat_d;
    logic        [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic        [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic                      wr_en;
    logic        [DATA_W-1:0]  step_res;
    logic                      step_sat;

    cheby_step u_step (
        .i_p   (p_q),
        .i_tm2 (tm2_q),
        .o_res (step_res),
        .o_sat (step_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            tm1_q     <= '0;
            tm2_q     <= '0;
            p_q       <= '0;
            k_q       <= '0;
            sat_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            tm1_q     <= tm1_d;
            tm2_q     <= tm2_d;
            p_q       <= p_d;
            k_q       <= k_d;
            sat_q     <= sat_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // The write port is driven from the current state so each word lands in its own cycle;
    // the _q copies keep address and data stable between strobes.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        tm1_d     = tm1_q;
        tm2_d     = tm2_q;
        p_d       = p_q;
        k_d       = k_q;
        sat_d     = sat_q;
        wr_en     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        o_busy    = 1'b0;
        o_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (c_start) begin
                    x_d     = i_x;
                    sat_d   = 1'b0;
                    state_d = SEED0;
                end
            end
            SEED0: begin
                o_busy    = 1'b1;
                wr_en     = 1'b1;
                wr_addr_d = '0;
                wr_data_d = T0_ONE;
                state_d   = SEED1;
            end
            SEED1: begin
                o_busy    = 1'b1;
                wr_en     = 1'b1;
                wr_addr_d = ADDR_W'(1);
                wr_data_d = x_q;
                tm1_d     = x_q;
                tm2_d     = T0_ONE;
                k_d       = K_FIRST;
                state_d   = MUL;
            end
            MUL: begin
                o_busy  = 1'b1;
                p_d     = x_q * tm1_q;
                state_d = WRITE;
            end
            WRITE: begin
                o_busy    = 1'b1;
                wr_en     = 1'b1;
                wr_addr_d = k_q;
                wr_data_d = step_res;
                tm2_d     = tm1_q;
                tm1_d     = step_res;
                sat_d     = sat_q | step_sat;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = MUL;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_wr_en      = wr_en;
    assign o_wr_address = wr_addr_d;
    assign o_wr_data    = wr_data_d;
    assign o_sat        = sat_q;

endmodule

// File: tb/tb_cheby_t_table_writer.sv
// Scoreboard bench for cheby_t_table_writer: expected writes (cycle, address, data) are
// queued at start and popped by a write monitor. Honours CHEBY_SAT_EN like the design.
module tb_cheby_t_table_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_x = 16'h0000;
    logic        c_start = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_wr_address;
    logic [15:0] o_wr_data;
    logic        o_wr_en;
    logic        o_sat;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] exp_t [8];
    logic        exp_sat;

    cheby_t_table_writer dut (
        .clk          (clk),
        .rst          (rst),
        .i_x          (i_x),
        .c_start      (c_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_wr_address (o_wr_address),
        .o_wr_data    (o_wr_data),
        .o_wr_en      (o_wr_en),
        .o_sat        (o_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference recurrence in wide integer arithmetic.
    function automatic void model(input logic [15:0] x);
        longint a, b, q, d;
        logic [15:0] w;
        exp_sat  = 1'b0;
        exp_t[0] = 16'h7FFF;
        exp_t[1] = x;
        b = 32767;
        a = longint'($signed(x));
        for (int k = 2; k < 8; k++) begin
            q = (a * longint'($signed(x))) >>> 14;
            d = q - b;
`ifdef CHEBY_SAT_EN
            if (d > 32767) begin
                d = 32767;
                exp_sat = 1'b1;
            end else if (d < -32768) begin
                d = -32768;
                exp_sat = 1'b1;
            end
`endif
            w = d[15:0];
            exp_t[k] = w;
            b = a;
            a = longint'($signed(w));
        end
    endfunction

    task automatic push_run(input int s, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = s + ((k < 2) ? k + 1 : 2 * k);
            e.addr = 3'(k);
            e.data = exp_t[k];
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int s, input string tag);
        for (int i = 0; i < 40 && !o_done; i++) tick();
        check({tag, "_done_cycle"}, 32'(cyc), 32'(s + 15));
        check({tag, "_busy_at_done"}, {31'b0, o_busy}, 32'd0);
        check({tag, "_sat"}, {31'b0, o_sat}, {31'b0, exp_sat});
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_hold_addr"}, {29'b0, o_wr_address}, 32'd7);
        check({tag, "_hold_data"}, {16'b0, o_wr_data}, {16'b0, exp_t[7]});
        tick();
        check({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
    endtask

    task automatic run_full(input logic [15:0] x, input string tag);
        int s;
        model(x);
        i_x = x;
        c_start = 1'b1;
        s = cyc;
        push_run(s, 8);
        tick();
        c_start = 1'b0;
        i_x = 16'($urandom);
        check({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
        wait_done(s, tag);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_wr_en) begin
            wr_t e;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %0d at cycle %0d expected no write", o_wr_address, cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                check("wr_addr", {29'b0, o_wr_address}, {29'b0, e.addr});
                check("wr_data", {16'b0, o_wr_data}, {16'b0, e.data});
                $display("[TB] write cyc=%0d addr=%0d data=%h", cyc, o_wr_address, o_wr_data);
            end
        end
    end

    initial begin
        int s;

        // Reset state
        tick();
        tick();
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("rst_addr", {29'b0, o_wr_address}, 32'd0);
        check("rst_data", {16'b0, o_wr_data}, 32'd0);
        check("rst_sat", {31'b0, o_sat}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        run_full(16'h0000, "x0");
        run_full(16'h7FFF, "xmax");
        run_full(16'h8000, "xmin");
        run_full(16'h4000, "xhalf");
        run_full(16'hC000, "xneghalf");
        run_full(16'h5A82, "x0p707");

        // Mid-run start pulses and i_x changes are ignored
        model(16'h3000);
        i_x = 16'h3000;
        c_start = 1'b1;
        s = cyc;
        push_run(s, 8);
        tick();
        c_start = 1'b0;
        i_x = 16'h7123;
        tick();
        tick();
        c_start = 1'b1;
        i_x = 16'h8111;
        tick();
        c_start = 1'b0;
        while (cyc < s + 9) tick();
        c_start = 1'b1;
        i_x = 16'h1234;
        tick();
        c_start = 1'b0;
        wait_done(s, "ignore");
        tick();
        tick();

        // Reset in cycle 7 abandons the run
        model(16'h2000);
        i_x = 16'h2000;
        c_start = 1'b1;
        s = cyc;
        push_run(s, 4);
        tick();
        c_start = 1'b0;
        while (cyc < s + 7) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        check("midrst_done", {31'b0, o_done}, 32'd0);
        check("midrst_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("midrst_addr", {29'b0, o_wr_address}, 32'd0);
        check("midrst_data", {16'b0, o_wr_data}, 32'd0);
        check("midrst_sat", {31'b0, o_sat}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        run_full(16'hE000, "after_rst");

        // Back-to-back runs with c_start held high
        model(16'h8000);
        i_x = 16'h8000;
        c_start = 1'b1;
        s = cyc;
        push_run(s, 8);
        push_run(s + 16, 8);
        while (cyc < s + 15) tick();
        check("b2b_done1", {31'b0, o_done}, 32'd1);
        check("b2b_sat1", {31'b0, o_sat}, {31'b0, exp_sat});
        tick();
        tick();
        c_start = 1'b0;
        check("b2b_sat_cleared", {31'b0, o_sat}, 32'd0);
        check("b2b_busy2", {31'b0, o_busy}, 32'd1);
        wait_done(s + 16, "b2b_run2");

        for (int i = 0; i < 4; i++) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
